// File: rtl/data_memory_unit_pkg.sv
// Shared CPU package: access-size encodings and memory-unit state encoding.
package data_memory_unit_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/data_memory_unit_if.sv
// Load/store request bus between a CPU core (master) and the data memory (slave).
//   req/we/size/sign_ext/address/write_data : request, master -> slave
//   ready/read_data/read_valid/misaligned   : status and response, slave -> master
interface data_memory_unit_if #(
  parameter int unsigned ADDR_W = 11
) ();
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W-1:0] address;
  logic [31:0]       write_data;
  logic              ready;
  logic [31:0]       read_data;
  logic              read_valid;
  logic              misaligned;

  modport master (
    output req, we, size, sign_ext, address, write_data,
    input  ready, read_data, read_valid, misaligned
  );

  modport slave (
    input  req, we, size, sign_ext, address, write_data,
    output ready, read_data, read_valid, misaligned
  );
endinterface

// File: rtl/data_memory_unit_load_align.sv
// Combinational load lane-select and extension.
//   word     : full 32-bit memory word
//   lane     : byte address within the word (little-endian)
//   size     : access size (byte/half/word)
//   sign_ext : 1 sign-extend, 0 zero-extend (byte/half only)
//   result   : right-aligned, extended load value
module load_align
  import data_memory_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane multiplexing; halfword lanes only ever start at 0 or 2.
  always_comb begin
    byte_sel = word[7:0];
    unique case (lane)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];
  end

  // Extension by access size.
  always_comb begin
    result = '0;
    unique case (size)
      SZ_BYTE: result = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SZ_HALF: result = {{16{sign_ext & half_sel[15]}}, half_sel};
      SZ_WORD: result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_unit.sv
// Byte-addressable data memory with zero-fill after reset.
//   clk   : single clock, all state on rising edge
//   reset : synchronous active-high reset; restarts zero-fill from word 0
//   bus   : slave side of data_memory_unit_if (request in, 1-cycle load response out)
module data_memory_unit
  import data_memory_unit_pkg::*;
#(
  parameter int unsigned RAM_SIZE     = 512,
  parameter int unsigned RAM_SIZE_BIT = 9
) (
  input  logic                clk,
  input  logic                reset,
  data_memory_unit_if.slave   bus
);

  localparam int unsigned LANES = 4;

  state_e                  state;
  logic [RAM_SIZE_BIT-1:0] clr_cnt;

  logic                    accept;
  logic                    bad;
  logic [RAM_SIZE_BIT-1:0] word_idx;
  logic [1:0]              lane;
  logic [LANES-1:0]        be;
  logic [31:0]             wdata;
  logic [7:0]              rd_lane [LANES];
  logic [31:0]             rd_word;
  logic [31:0]             aligned;

  // Request decode: acceptance, alignment check, lane enables, lane-replicated store data.
  always_comb begin
    accept   = 1'b0;
    bad      = 1'b0;
    be       = '0;
    wdata    = bus.write_data;
    word_idx = bus.address[RAM_SIZE_BIT+1:2];
    lane     = bus.address[1:0];
    accept   = bus.req & bus.ready;
    unique case (bus.size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'd0);
      default: bad = 1'b1;
    endcase
    unique case (bus.size)
      SZ_BYTE: wdata = {4{bus.write_data[7:0]}};
      SZ_HALF: wdata = {2{bus.write_data[15:0]}};
      default: wdata = bus.write_data;
    endcase
    if (accept && !bad && bus.we) begin
      unique case (bus.size)
        SZ_BYTE: be = LANES'(4'b0001 << lane);
        SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
        default: be = 4'b1111;
      endcase
    end
  end

  // One 8-bit array per lane; INIT zero-fills, RUN applies lane-enabled stores.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] mem [RAM_SIZE];

    always_ff @(posedge clk) begin
      if (!reset) begin
        if (state == ST_INIT) begin
          mem[clr_cnt] <= '0;
        end else if (be[l]) begin
          mem[word_idx] <= wdata[8*l +: 8];
        end
      end
    end

    assign rd_lane[l] = mem[word_idx];
  end

  assign rd_word = {rd_lane[3], rd_lane[2], rd_lane[1], rd_lane[0]};

  load_align u_load_align (
    .word     (rd_word),
    .lane     (lane),
    .size     (bus.size),
    .sign_ext (bus.sign_ext),
    .result   (aligned)
  );

  // Control FSM with registered status and response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_INIT;
      clr_cnt        <= '0;
      bus.ready      <= 1'b0;
      bus.read_valid <= 1'b0;
      bus.misaligned <= 1'b0;
      bus.read_data  <= '0;
    end else begin
      bus.read_valid <= 1'b0;
      bus.misaligned <= 1'b0;
      unique case (state)
        ST_INIT: begin
          if (clr_cnt == RAM_SIZE_BIT'(RAM_SIZE - 1)) begin
            state     <= ST_RUN;
            bus.ready <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + RAM_SIZE_BIT'(1);
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (bad) begin
              bus.misaligned <= 1'b1;
            end else if (!bus.we) begin
              bus.read_valid <= 1'b1;
              bus.read_data  <= aligned;
            end
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: doc/data_memory_unit.md
DATA_MEMORY_UNIT -- requirements
Module: data_memory_unit

Interface
REQ-001 SHALL have parameter RAM_SIZE, default 512, meaning depth in 32-bit words (power of two).
REQ-002 SHALL have parameter RAM_SIZE_BIT, default 9, meaning log2(RAM_SIZE), the word-address width.
REQ-003 SHALL have clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ready  output  1  high when requests are accepted (RUN state).
REQ-006 SHALL have req  input  1  request valid this cycle.
REQ-007 SHALL have we  input  1  1 = store, 0 = load.
REQ-008 SHALL have size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 SHALL have sign_ext  input  1  loads: 1 sign-extend, 0 zero-extend.
REQ-010 SHALL have address  input  RAM_SIZE_BIT+2  byte address.
REQ-011 SHALL have write_data  input  32  store data, right-aligned (bits [7:0] for byte, [15:0] for half).
REQ-012 SHALL have read_data  output  32  aligned, extended load result.
REQ-013 SHALL have read_valid  output  1  one-cycle pulse marking read_data as new.
REQ-014 SHALL have misaligned  output  1  one-cycle pulse flagging a rejected request.

Function
REQ-015 SHALL implement states INIT and RUN; reset enters INIT; INIT moves to RUN after clearing the last word.
REQ-016 In INIT, SHALL write 0 to word clr_cnt each cycle, clr_cnt 0..RAM_SIZE-1, so RUN is reached exactly RAM_SIZE cycles after reset deasserts; ready=0 throughout INIT.
REQ-017 SHALL ignore req while ready=0 (no write, no read_valid, no misaligned).
REQ-018 Word index SHALL be address[RAM_SIZE_BIT+1:2]; byte lane = address[1:0], little-endian (lane 0 = bits [7:0]).
REQ-019 Store accepted in cycle N SHALL update only the addressed lane(s) at the end of N: byte -> 1 lane, half -> lanes {address[1],0}+{0,1}, word -> all 4.
REQ-020 Load accepted in cycle N SHALL drive read_data and pulse read_valid in cycle N+1 (latency 1); one request per cycle, full throughput.
REQ-021 Load SHALL extract the addressed byte/half and extend it to 32 bits per sign_ext; word loads ignore sign_ext.
REQ-022 A load in N+1 to a location stored in N SHALL return the new data.
REQ-023 read_data SHALL hold its last value until the next valid load completes.
REQ-024 Half with address[0]=1, word with address[1:0]!=0, or size=11 SHALL be rejected: no memory change, no read_valid, misaligned pulsed in N+1.
REQ-025 Reset asserted mid-operation SHALL discard any pending load response (read_valid=0 next cycle) and restart INIT from word 0.

Reset
REQ-026 On reset: state=INIT, clr_cnt=0, ready=0, read_valid=0, misaligned=0, read_data=0.
REQ-027 Memory contents SHALL be all-zero once ready first rises after reset.

Structure
REQ-028 Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state encoding SHALL live in the shared CPU package.
REQ-029 Load lane-select/extension SHALL be a combinational sub-module load_align (inputs word, lane, size, sign_ext; output 32-bit result).
REQ-030 Storage SHALL be four 8-bit-wide arrays of RAM_SIZE entries, one per lane, each with its own write enable.

Verification
REQ-031 Reset held 1 cycle then released -> ready=0 for exactly 512 cycles, then 1; load word 0x000 returns 0x00000000.
REQ-032 Store word 0x11223344 @0x010; load byte @0x013 sign_ext=1 -> 0x00000011; load half @0x012 -> 0x00001122; load byte @0x010 -> 0x00000044.
REQ-033 Store byte 0x80 @0x021 over word 0; load byte sign_ext=1 @0x021 -> 0xFFFFFF80, sign_ext=0 -> 0x00000080, load word @0x020 -> 0x00008000.
REQ-034 Store word 0xDEADBEEF @0x040 in N, load word @0x040 in N+1 -> read_valid in N+2 with 0xDEADBEEF; back-to-back loads pulse read_valid every cycle.
REQ-035 Store half @0x031, store word @0x042, size=11 request -> misaligned pulses, read_valid stays 0, subsequent word load @0x030 and @0x040 unchanged.
REQ-036 Reset asserted the cycle after a load is accepted -> read_valid=0, ready=0, full INIT repeated, previously stored data reads as 0.
